mrna_iso_valve_seq: RTL and testbench

//  Control-side sequencer for the mRNA isolation bank. It drives the 13 control-layer valve

---
 rtl/mrna_iso_valve_seq_if.sv | 38 +++
 rtl/mrna_iso_valve_seq.sv | 179 +++++++++++++++++
 tb/tb_mrna_iso_valve_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mrna_iso_valve_seq_if.sv
// Host-side bundle for the mRNA isolation sequencer: command inputs, status and the
// 13 pneumatic control lines (1 = pressurised/closed, 0 = vented/open).
interface mrna_iso_valve_seq_if;
  logic       start;
  logic       abort;
  logic       hold;
  logic       busy;
  logic       done;
  logic       aborted;
  logic [3:0] state;
  logic       cells_in_ctrl;
  logic       cells_out_ctrl;
  logic       beads_ctrl;
  logic       lysis_in_ctrl;
  logic       lysis_out_ctrl;
  logic       pump1;
  logic       pump2;
  logic       pump3;
  logic       sep_ctrl;
  logic       sieve_ctrl;
  logic       waste_ctrl;
  logic       push_ctrl;
  logic       collect_ctrl;

  modport master (
    output start, abort, hold,
    input  busy, done, aborted, state,
    input  cells_in_ctrl, cells_out_ctrl, beads_ctrl, lysis_in_ctrl, lysis_out_ctrl,
    input  pump1, pump2, pump3, sep_ctrl, sieve_ctrl, waste_ctrl, push_ctrl, collect_ctrl
  );

  modport slave (
    input  start, abort, hold,
    output busy, done, aborted, state,
    output cells_in_ctrl, cells_out_ctrl, beads_ctrl, lysis_in_ctrl, lysis_out_ctrl,
    output pump1, pump2, pump3, sep_ctrl, sieve_ctrl, waste_ctrl, push_ctrl, collect_ctrl
  );
endinterface

// File: rtl/mrna_iso_valve_seq.sv
// Sequencer driving the mRNA isolation bank valves through
// load -> lyse -> mix -> separate -> waste -> collect -> flush, with abort and hold.
module mrna_iso_valve_seq #(
  parameter int TMR_W       = 16,
  parameter int LOAD_TICKS  = 16,
  parameter int LYSE_TICKS  = 32,
  parameter int PHASE_TICKS = 4,
  parameter int MIX_CYCLES  = 8,
  parameter int SEP_TICKS   = 16,
  parameter int FLUSH_TICKS = 8
) (
  input logic                 clk,
  input logic                 rst,
  mrna_iso_valve_seq_if.slave ctrl_if
);

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOAD_CELLS = 4'd1,
    S_LOAD_BEADS = 4'd2,
    S_LYSE       = 4'd3,
    S_MIX        = 4'd4,
    S_SEPARATE   = 4'd5,
    S_WASTE      = 4'd6,
    S_COLLECT    = 4'd7,
    S_FLUSH      = 4'd8
  } state_e;

  // Reload values are N-1 so a state lasts exactly N cycles; a tick count of 0 acts as 1.
  localparam logic [TMR_W-1:0] LOAD_RL  = (LOAD_TICKS  > 1) ? TMR_W'(LOAD_TICKS  - 1) : '0;
  localparam logic [TMR_W-1:0] LYSE_RL  = (LYSE_TICKS  > 1) ? TMR_W'(LYSE_TICKS  - 1) : '0;
  localparam logic [TMR_W-1:0] PHASE_RL = (PHASE_TICKS > 1) ? TMR_W'(PHASE_TICKS - 1) : '0;
  localparam logic [TMR_W-1:0] SEP_RL   = (SEP_TICKS   > 1) ? TMR_W'(SEP_TICKS   - 1) : '0;
  localparam logic [TMR_W-1:0] FLUSH_RL = (FLUSH_TICKS > 1) ? TMR_W'(FLUSH_TICKS - 1) : '0;
  localparam logic [15:0]      ROT_LAST = (MIX_CYCLES  > 1) ? 16'(MIX_CYCLES - 1)     : '0;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       phase_q, phase_d;
  logic [15:0]      rot_q, rot_d;
  logic             abortSeen_q, abortSeen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;
  logic [12:0]      valves_q, valves_d;

  // Bit order: cells_in, cells_out, beads, lysis_in, lysis_out, pump1..3, sep, sieve, waste, push, collect.
  function automatic logic [12:0] valveMap(state_e s, logic [1:0] p);
    logic [12:0] v;
    v = '1;
    case (s)
      S_LOAD_CELLS: begin v[12] = 1'b0; v[11] = 1'b0; v[3] = 1'b0; end
      S_LOAD_BEADS: begin v[10] = 1'b0; v[3] = 1'b0; end
      S_LYSE:       begin v[9] = 1'b0; v[8] = 1'b0; end
      S_MIX: begin
        case (p)
          2'd0:    v[7] = 1'b0;
          2'd1:    v[6] = 1'b0;
          2'd2:    v[5] = 1'b0;
          default: v = '1;
        endcase
      end
      S_SEPARATE:   v[4] = 1'b0;
      S_WASTE:      begin v[2] = 1'b0; v[1] = 1'b0; end
      S_COLLECT:    begin v[0] = 1'b0; v[1] = 1'b0; end
      S_FLUSH:      begin v[2] = 1'b0; v[1] = 1'b0; v[3] = 1'b0; end
      default:      v = '1;
    endcase
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      phase_q     <= '0;
      rot_q       <= '0;
      abortSeen_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      valves_q    <= '1;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      phase_q     <= phase_d;
      rot_q       <= rot_d;
      abortSeen_q <= abortSeen_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      valves_q    <= valves_d;
    end
  end

  // Abort wins over hold in the working states; hold freezes everything else.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    phase_d     = phase_q;
    rot_d       = rot_q;
    abortSeen_d = abortSeen_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;

    if (state_q == S_IDLE) begin
      if (ctrl_if.start && !ctrl_if.abort) begin
        state_d     = S_LOAD_CELLS;
        timer_d     = LOAD_RL;
        abortSeen_d = 1'b0;
      end
    end else if (ctrl_if.abort && state_q != S_FLUSH) begin
      state_d     = S_FLUSH;
      timer_d     = FLUSH_RL;
      abortSeen_d = 1'b1;
    end else if (!ctrl_if.hold) begin
      if (timer_q != '0) begin
        timer_d = timer_q - 1'b1;
      end else begin
        case (state_q)
          S_LOAD_CELLS: begin state_d = S_LOAD_BEADS; timer_d = LOAD_RL;  end
          S_LOAD_BEADS: begin state_d = S_LYSE;       timer_d = LYSE_RL;  end
          S_LYSE: begin
            state_d = S_MIX;
            timer_d = PHASE_RL;
            phase_d = 2'd0;
            rot_d   = '0;
          end
          S_MIX: begin
            if (phase_q == 2'd2 && rot_q == ROT_LAST) begin
              state_d = S_SEPARATE;
              timer_d = SEP_RL;
            end else begin
              timer_d = PHASE_RL;
              if (phase_q == 2'd2) begin
                phase_d = 2'd0;
                rot_d   = rot_q + 16'd1;
              end else begin
                phase_d = phase_q + 2'd1;
              end
            end
          end
          S_SEPARATE:   begin state_d = S_WASTE;   timer_d = SEP_RL;   end
          S_WASTE:      begin state_d = S_COLLECT; timer_d = SEP_RL;   end
          S_COLLECT:    begin state_d = S_FLUSH;   timer_d = FLUSH_RL; end
          S_FLUSH: begin
            state_d     = S_IDLE;
            done_d      = !abortSeen_q;
            aborted_d   = abortSeen_q;
            abortSeen_d = 1'b0;
          end
          default:      state_d = S_IDLE;
        endcase
      end
    end

    busy_d   = (state_d != S_IDLE);
    valves_d = valveMap(state_d, phase_d);
  end

  assign ctrl_if.busy           = busy_q;
  assign ctrl_if.done           = done_q;
  assign ctrl_if.aborted        = aborted_q;
  assign ctrl_if.state          = state_q;
  assign ctrl_if.cells_in_ctrl  = valves_q[12];
  assign ctrl_if.cells_out_ctrl = valves_q[11];
  assign ctrl_if.beads_ctrl     = valves_q[10];
  assign ctrl_if.lysis_in_ctrl  = valves_q[9];
  assign ctrl_if.lysis_out_ctrl = valves_q[8];
  assign ctrl_if.pump1          = valves_q[7];
  assign ctrl_if.pump2          = valves_q[6];
  assign ctrl_if.pump3          = valves_q[5];
  assign ctrl_if.sep_ctrl       = valves_q[4];
  assign ctrl_if.sieve_ctrl     = valves_q[3];
  assign ctrl_if.waste_ctrl     = valves_q[2];
  assign ctrl_if.push_ctrl      = valves_q[1];
  assign ctrl_if.collect_ctrl   = valves_q[0];

endmodule

// File: tb/tb_mrna_iso_valve_seq.sv
// Scoreboard bench for mrna_iso_valve_seq: expected per-cycle outputs are queued by
// the stimulus and popped by a negedge monitor.
module tb_mrna_iso_valve_seq;

  typedef struct {
    int          cyc;
    logic [3:0]  st;
    logic [12:0] v;
    logic        busy;
    logic        done;
    logic        aborted;
  } exp_t;

  localparam logic [12:0] ALL  = 13'h1FFF;
  localparam logic [12:0] V_ID = ALL;
  localparam logic [12:0] V_LC = ALL ^ ((13'd1 << 12) | (13'd1 << 11) | (13'd1 << 3));
  localparam logic [12:0] V_LB = ALL ^ ((13'd1 << 10) | (13'd1 << 3));
  localparam logic [12:0] V_LY = ALL ^ ((13'd1 << 9) | (13'd1 << 8));
  localparam logic [12:0] V_P1 = ALL ^ (13'd1 << 7);
  localparam logic [12:0] V_P2 = ALL ^ (13'd1 << 6);
  localparam logic [12:0] V_P3 = ALL ^ (13'd1 << 5);
  localparam logic [12:0] V_SP = ALL ^ (13'd1 << 4);
  localparam logic [12:0] V_WS = ALL ^ ((13'd1 << 2) | (13'd1 << 1));
  localparam logic [12:0] V_CL = ALL ^ ((13'd1 << 0) | (13'd1 << 1));
  localparam logic [12:0] V_FL = ALL ^ ((13'd1 << 2) | (13'd1 << 1) | (13'd1 << 3));
  localparam int          NOLIM = 32'h7fffffff;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        q[$];
  logic [12:0] vv;

  mrna_iso_valve_seq_if bus();

  mrna_iso_valve_seq dut (
    .clk     (clk),
    .rst     (rst),
    .ctrl_if (bus)
  );

  assign vv = {bus.cells_in_ctrl, bus.cells_out_ctrl, bus.beads_ctrl, bus.lysis_in_ctrl,
               bus.lysis_out_ctrl, bus.pump1, bus.pump2, bus.pump3, bus.sep_ctrl,
               bus.sieve_ctrl, bus.waste_ctrl, bus.push_ctrl, bus.collect_ctrl};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic applyStimulus(input logic s, input logic a, input logic h);
    bus.start = s;
    bus.abort = a;
    bus.hold  = h;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [17:0] got, want;
    got  = {bus.state, vv, bus.busy, bus.done, bus.aborted};
    want = {e.st, e.v, e.busy, e.done, e.aborted};
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL cycle%0d state/valves/busy/done/aborted got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b",
               e.cyc, bus.state, vv, bus.busy, bus.done, bus.aborted,
               e.st, e.v, e.busy, e.done, e.aborted);
    end
  endtask

  task automatic pushCyc(input int c, input int st, input logic [12:0] v,
                         input logic b, input logic d, input logic a);
    exp_t e;
    e.cyc = c; e.st = 4'(st); e.v = v; e.busy = b; e.done = d; e.aborted = a;
    q.push_back(e);
  endtask

  task automatic pushSeg(inout int c, input int st, input int len,
                         input logic [12:0] v, input int lim);
    for (int i = 0; i < len; i++) begin
      if (c <= lim) pushCyc(c, st, v, 1'b1, 1'b0, 1'b0);
      c++;
    end
  endtask

  // Expected busy cycles of one run started at edge b; cut>0 truncates after cycle b+cut.
  task automatic pushRun(input int b, input int sepLen, input int cut, input bit abortTail);
    int c;
    int lim;
    c   = b + 1;
    lim = (cut > 0) ? b + cut : NOLIM;
    pushSeg(c, 1, 16, V_LC, lim);
    pushSeg(c, 2, 16, V_LB, lim);
    pushSeg(c, 3, 32, V_LY, lim);
    for (int r = 0; r < 8; r++) begin
      pushSeg(c, 4, 4, V_P1, lim);
      pushSeg(c, 4, 4, V_P2, lim);
      pushSeg(c, 4, 4, V_P3, lim);
    end
    pushSeg(c, 5, sepLen, V_SP, lim);
    pushSeg(c, 6, 16, V_WS, lim);
    pushSeg(c, 7, 16, V_CL, lim);
    if (abortTail) begin
      c = lim + 1;
      pushSeg(c, 8, 8, V_FL, NOLIM);
      pushCyc(c, 0, V_ID, 1'b0, 1'b0, 1'b1);
      pushCyc(c + 1, 0, V_ID, 1'b0, 1'b0, 1'b0);
    end else if (cut == 0) begin
      pushSeg(c, 8, 8, V_FL, NOLIM);
      pushCyc(c, 0, V_ID, 1'b0, 1'b1, 1'b0);
      pushCyc(c + 1, 0, V_ID, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare every queued expectation due at this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc < cyc) begin
          total++;
          bad++;
          $display("[TB] FAIL cycle%0d missed: now %0d want %0d", e.cyc, cyc, e.cyc);
        end else begin
          checkOutput(e);
        end
      end
    end
  end

  initial begin
    int b;
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    // Reset held for three edges, then released.
    @(negedge clk);
    pushCyc(cyc + 1, 0, V_ID, 1'b0, 1'b0, 1'b0);
    pushCyc(cyc + 2, 0, V_ID, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    pushCyc(cyc + 1, 0, V_ID, 1'b0, 1'b0, 1'b0);
    pushCyc(cyc + 2, 0, V_ID, 1'b0, 1'b0, 1'b0);
    waitUntil(cyc + 3);

    // Full uninterrupted run.
    $display("[TB] full run");
    b = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushRun(b, 16, 0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(b + 219);

    // Abort in the 5th LYSE cycle.
    $display("[TB] abort in lyse");
    b = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushRun(b, 16, 37, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(b + 37);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(b + 48);

    // Hold for 10 cycles inside SEPARATE, plus a stray start while busy.
    $display("[TB] hold in separate");
    b = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushRun(b, 26, 0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(b + 100);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(b + 165);
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(b + 229);

    // Reset while pump2 is open, then start+abort together in IDLE.
    $display("[TB] reset mid-mix");
    b = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0);
    pushRun(b, 16, 70, 1'b0);
    pushCyc(b + 71, 0, V_ID, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(b + 70);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    b = cyc;
    applyStimulus(1'b1, 1'b1, 1'b0);
    pushCyc(b + 1, 0, V_ID, 1'b0, 1'b0, 1'b0);
    pushCyc(b + 2, 0, V_ID, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitUntil(b + 3);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      total++;
      bad++;
      $display("[TB] FAIL cycle%0d unchecked: now %0d want %0d", e.cyc, cyc, e.cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
